// File: rtl/regfile_writeback.sv
// Write-side master for the 32x32 register file. ALU results and returning load data
// share the single regfile write port. A small FIFO buffers load returns, and a busy
// scoreboard tracks the destinations of loads that are still in flight.
module regfile_writeback #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  output logic            ld_issue_ready,
  input  logic [4:0]      ld_issue_rd,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [4:0]      mem_rsp_rd,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wen,
  output logic [4:0]      wdest,
  output logic [XLEN-1:0] wdata,
  output logic            err
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 2);

  logic [4:0]      fifoRd_q   [LQ_DEPTH];
  logic [XLEN-1:0] fifoData_q [LQ_DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   fifoCount_q, fifoCount_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [SW-1:0]   starveCnt_q, starveCnt_d;
  logic [31:0]     busy_q, busy_d;
  logic            wen_q, wen_d;
  logic [4:0]      wdest_q, wdest_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            loadWrite_q, loadWrite_d;
  logic            err_q, err_d;

  logic fifoEmpty;
  logic fifoFull;
  logic starveMax;
  logic aluAccept;
  logic popHead;
  logic rspAccept;
  logic issueAccept;
  logic loadCommit;
  logic [4:0] headRd;
  logic [XLEN-1:0] headData;

  // Handshakes and arbitration: the ALU normally wins, unless a buffered load has lost too often
  always_comb begin
    fifoEmpty      = (fifoCount_q == '0);
    fifoFull       = (fifoCount_q == CW'(LQ_DEPTH));
    starveMax      = (starveCnt_q == SW'(STARVE_LIMIT));
    alu_ready      = ~(~fifoEmpty & starveMax);
    aluAccept      = alu_valid & alu_ready;
    popHead        = ~fifoEmpty & ~aluAccept;
    mem_rsp_ready  = ~fifoFull;
    rspAccept      = mem_rsp_valid & mem_rsp_ready;
    ld_issue_ready = (outstanding_q != CW'(LQ_DEPTH));
    issueAccept    = ld_issue_valid & ld_issue_ready;
    loadCommit     = loadWrite_q & wen_q;
    headRd         = fifoRd_q[rdPtr_q];
    headData       = fifoData_q[rdPtr_q];
  end

  // Hazard query: a source whose pending load is being written this very cycle is already free
  always_comb begin
    rs1_busy = (rs1 != 5'd0) & busy_q[rs1] & ~(loadCommit & (wdest_q == rs1));
    rs2_busy = (rs2 != 5'd0) & busy_q[rs2] & ~(loadCommit & (wdest_q == rs2));
  end

  // Next write-port contents; x0 destinations complete their handshake but never raise wen
  always_comb begin
    wen_d       = 1'b0;
    wdest_d     = wdest_q;
    wdata_d     = wdata_q;
    loadWrite_d = 1'b0;
    if (aluAccept) begin
      wen_d   = (alu_rd != 5'd0);
      wdest_d = alu_rd;
      wdata_d = alu_data;
    end else if (popHead) begin
      wen_d       = (headRd != 5'd0);
      wdest_d     = headRd;
      wdata_d     = headData;
      loadWrite_d = 1'b1;
    end
  end

  // FIFO pointers, outstanding-load count and starvation counter
  always_comb begin
    wrPtr_d       = rspAccept ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d       = popHead ? rdPtr_q + PW'(1) : rdPtr_q;
    fifoCount_d   = fifoCount_q + CW'(rspAccept) - CW'(popHead);
    outstanding_d = outstanding_q + CW'(issueAccept) - CW'(loadWrite_q);
    starveCnt_d   = starveCnt_q;
    if (popHead) begin
      starveCnt_d = '0;
    end else if (~fifoEmpty & aluAccept) begin
      starveCnt_d = starveCnt_q + SW'(1);
    end
  end

  // Scoreboard update: the clear from a committing load is applied first so a same-index set wins
  always_comb begin
    busy_d = busy_q;
    if (loadCommit) begin
      busy_d[wdest_q] = 1'b0;
    end
    if (issueAccept & (ld_issue_rd != 5'd0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky protocol-violation detection
  always_comb begin
    err_d = err_q
          | (aluAccept & (alu_rd != 5'd0) & busy_q[alu_rd])
          | (issueAccept & (ld_issue_rd != 5'd0) & busy_q[ld_issue_rd])
          | (rspAccept & (mem_rsp_rd != 5'd0) & ~busy_q[mem_rsp_rd])
          | (mem_rsp_valid & (outstanding_q == '0));
  end

  // Control and output state; reset discards every in-flight load
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      fifoCount_q   <= '0;
      outstanding_q <= '0;
      starveCnt_q   <= '0;
      busy_q        <= '0;
      wen_q         <= 1'b0;
      wdest_q       <= '0;
      wdata_q       <= '0;
      loadWrite_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      fifoCount_q   <= fifoCount_d;
      outstanding_q <= outstanding_d;
      starveCnt_q   <= starveCnt_d;
      busy_q        <= busy_d;
      wen_q         <= wen_d;
      wdest_q       <= wdest_d;
      wdata_q       <= wdata_d;
      loadWrite_q   <= loadWrite_d;
      err_q         <= err_d;
    end
  end

  // FIFO storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (rspAccept) begin
      fifoRd_q[wrPtr_q]   <= mem_rsp_rd;
      fifoData_q[wrPtr_q] <= mem_rsp_data;
    end
  end

  // Registered outputs straight from state
  always_comb begin
    wen   = wen_q;
    wdest = wdest_q;
    wdata = wdata_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_regfile_writeback;

  localparam int XLEN         = 32;
  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue_valid, ld_issue_ready;
  logic [4:0]      ld_issue_rd;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [4:0]      mem_rsp_rd;
  logic [XLEN-1:0] mem_rsp_data;
  logic [4:0]      rs1, rs2;
  logic            rs1_busy, rs2_busy;
  logic            wen;
  logic [4:0]      wdest;
  logic [XLEN-1:0] wdata;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          mBusy [32];
  logic [36:0] mQ [$];
  int          mOut;
  int          mStarve;
  bit          mWen;
  bit          mLoadWrite;
  bit          mErr;
  logic [4:0]  mWdest;
  logic [31:0] mWdata;
  bit          modelValid = 1'b0;

  // Destinations issued by the random driver whose memory response has not been sent
  logic [4:0] pend [$];

  regfile_writeback #(
    .XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rd(mem_rsp_rd),
    .mem_rsp_data(mem_rsp_data),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wen(wen), .wdest(wdest), .wdata(wdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic bit expAluReady();
    return !(mQ.size() != 0 && mStarve == STARVE_LIMIT);
  endfunction

  function automatic bit expRsBusy(input logic [4:0] r);
    return (r != 5'd0) && mBusy[r] && !(mLoadWrite && mWen && mWdest == r);
  endfunction

  // Model: one write per cycle chosen by the starvation rule, loads queued in arrival order
  always @(posedge clk) begin
    if (rst) begin
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mQ.delete();
      mOut       = 0;
      mStarve    = 0;
      mWen       = 1'b0;
      mLoadWrite = 1'b0;
      mErr       = 1'b0;
      mWdest     = '0;
      mWdata     = '0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      bit aluAcc, pop, issue, push;
      logic [36:0] head;
      aluAcc = alu_valid && expAluReady();
      pop    = (mQ.size() != 0) && !aluAcc;
      issue  = ld_issue_valid && (mOut != LQ_DEPTH);
      push   = mem_rsp_valid && (mQ.size() != LQ_DEPTH);
      if (aluAcc && alu_rd != 0 && mBusy[alu_rd]) mErr = 1'b1;
      if (issue && ld_issue_rd != 0 && mBusy[ld_issue_rd]) mErr = 1'b1;
      if (push && mem_rsp_rd != 0 && !mBusy[mem_rsp_rd]) mErr = 1'b1;
      if (mem_rsp_valid && mOut == 0) mErr = 1'b1;
      if (mLoadWrite && mWen) mBusy[mWdest] = 1'b0;
      if (issue && ld_issue_rd != 0) mBusy[ld_issue_rd] = 1'b1;
      mOut = mOut + int'(issue) - int'(mLoadWrite);
      if (pop) mStarve = 0;
      else if (mQ.size() != 0 && aluAcc) mStarve++;
      mLoadWrite = 1'b0;
      if (aluAcc) begin
        mWen   = (alu_rd != 0);
        mWdest = alu_rd;
        mWdata = alu_data;
      end else if (pop) begin
        head       = mQ.pop_front();
        mWen       = (head[36:32] != 0);
        mWdest     = head[36:32];
        mWdata     = head[31:0];
        mLoadWrite = 1'b1;
      end else begin
        mWen = 1'b0;
      end
      if (push) mQ.push_back({mem_rsp_rd, mem_rsp_data});
    end
  end

  // Compare every DUT output against the model in the middle of each cycle
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("alu_ready", alu_ready, expAluReady());
      checkOutput("ld_issue_ready", ld_issue_ready, mOut != LQ_DEPTH);
      checkOutput("mem_rsp_ready", mem_rsp_ready, mQ.size() != LQ_DEPTH);
      checkOutput("rs1_busy", rs1_busy, expRsBusy(rs1));
      checkOutput("rs2_busy", rs2_busy, expRsBusy(rs2));
      checkOutput("wen", wen, mWen);
      checkOutput("err", err, mErr);
      if (mWen) begin
        checkOutput("wdest", wdest, mWdest);
        checkOutput("wdata", wdata, mWdata);
      end
    end
  end

  task automatic applyStimulus(
    input bit doAlu, input logic [4:0] aRd, input logic [31:0] aData,
    input bit doIssue, input logic [4:0] iRd,
    input bit doRsp, input logic [4:0] rRd, input logic [31:0] rData,
    input logic [4:0] r1, input logic [4:0] r2);
    alu_valid      = doAlu;
    alu_rd         = aRd;
    alu_data       = aData;
    ld_issue_valid = doIssue;
    ld_issue_rd    = iRd;
    mem_rsp_valid  = doRsp;
    mem_rsp_rd     = rRd;
    mem_rsp_data   = rData;
    rs1            = r1;
    rs2            = r2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomCycle();
    bit doAlu, doIssue, doRsp;
    logic [4:0] aRd, iRd, rRd;
    int k;
    doAlu = bit'($urandom_range(0, 1));
    aRd   = 5'($urandom_range(0, 31));
    if (mBusy[aRd]) aRd = 5'd0;
    doRsp = 1'b0;
    rRd   = 5'd0;
    if (pend.size() != 0 && mQ.size() != LQ_DEPTH && $urandom_range(0, 1) == 1) begin
      k     = $urandom_range(0, pend.size() - 1);
      rRd   = pend[k];
      pend.delete(k);
      doRsp = 1'b1;
    end
    doIssue = ($urandom_range(0, 2) == 0);
    iRd     = 5'($urandom_range(0, 31));
    if (mBusy[iRd]) doIssue = 1'b0;
    if (doIssue && mOut != LQ_DEPTH) pend.push_back(iRd);
    applyStimulus(doAlu, aRd, $urandom, doIssue, iRd, doRsp, rRd, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    nextCycle();
    nextCycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_wdest", wdest, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ld_ready", ld_issue_ready, 1);
    checkOutput("rst_alu_ready", alu_ready, 1);
    nextCycle();

    // Single ALU write with one-cycle latency
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("alu_wen", wen, 1);
    checkOutput("alu_wdest", wdest, 5);
    checkOutput("alu_wdata", wdata, 32'hDEADBEEF);
    checkOutput("model_alu_wdata", mWdata, 32'hDEADBEEF);
    nextCycle();
    @(negedge clk);
    checkOutput("alu_wen_drop", wen, 0);
    nextCycle();

    // Load to x7 waiting behind a continuous ALU stream
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
    nextCycle();
    applyStimulus(1, 3, 32'h100, 0, 0, 1, 7, 32'h1234, 7, 0);
    @(negedge clk);
    checkOutput("ld_rs1_busy", rs1_busy, 1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 3, 32'h101 + i, 0, 0, 0, 0, 0, 7, 0);
      @(negedge clk);
      checkOutput("starve_alu_ready", alu_ready, (i < 3) ? 1 : 0);
      if (i == 3) begin
        checkOutput("starve_rs1_busy", rs1_busy, 1);
        checkOutput("model_starve", mStarve, STARVE_LIMIT);
      end
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    checkOutput("ld_wen", wen, 1);
    checkOutput("ld_wdest", wdest, 7);
    checkOutput("ld_wdata", wdata, 32'h1234);
    checkOutput("ld_rs1_bypass", rs1_busy, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("ld_rs1_free", rs1_busy, 0);
    checkOutput("ld_starve_cleared", mStarve, 0);
    idle();
    nextCycle();

    // Fill the outstanding-load limit, then retire one
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 5'(10 + i), 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("lq_ready_fill", ld_issue_ready, 1);
      nextCycle();
    end
    idle();
    @(negedge clk);
    checkOutput("lq_ready_full", ld_issue_ready, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 10, 32'hA0, 0, 0);
    @(negedge clk);
    checkOutput("lq_ready_rsp", ld_issue_ready, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("lq_ready_pop", ld_issue_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("lq_ready_write", ld_issue_ready, 0);
    checkOutput("lq_wen", wen, 1);
    checkOutput("lq_wdest", wdest, 10);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 5'(11 + i), 32'hA1 + i, 0, 0);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("lq_ready_after", ld_issue_ready, 1);
      end
      nextCycle();
    end
    idle();
    repeat (6) nextCycle();

    // x0 destinations from both sources
    applyStimulus(1, 0, 32'h55, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("x0_alu_ready", alu_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h66, 0, 0);
    @(negedge clk);
    checkOutput("x0_wen_alu", wen, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("x0_wen_pop", wen, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("x0_wen_ld", wen, 0);
    checkOutput("x0_err", err, 0);
    nextCycle();
    nextCycle();

    // ALU write to a load-busy register, then reset with loads pending
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("viol_err", err, 1);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("viol_err_sticky", err, 1);
    applyStimulus(0, 0, 0, 1, 20, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 20);
    @(negedge clk);
    checkOutput("pre_rst_rs1_busy", rs1_busy, 1);
    checkOutput("pre_rst_rs2_busy", rs2_busy, 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_wen", wen, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_rs1_busy", rs1_busy, 0);
    checkOutput("mid_rst_rs2_busy", rs2_busy, 0);
    checkOutput("mid_rst_ld_ready", ld_issue_ready, 1);
    nextCycle();

    // Randomized legal traffic with occasional mid-run resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle();
        rst = 1'b1;
        pend.delete();
        nextCycle();
        rst = 1'b0;
      end else begin
        randomCycle();
        nextCycle();
      end
    end
    idle();
    repeat (10) nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
